// File: rtl/decoder_onehot_reg.sv
// -----------------------------------------------------------------------------
// decoder_onehot_reg
//
// Registered binary-to-one-hot decoder (3-to-8 by default). A select code
// accepted on a rising edge (en=1 and sel_valid=1) appears as a single active
// output line one cycle later. Downstream per-line enables (bank or lane
// selects) therefore see clean, clock-aligned levels.
//
// Parameters:
//   SEL_W      width of the select code
//   OUT_W      number of output lines, 1..2**SEL_W
//   ACTIVE_LOW 1 inverts every output line (one-cold decode)
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   en          decoder enable; when low, the outputs go inactive on the next edge
//   sel_valid   sel is meaningful this cycle
//   sel         binary select code
//   dec_out     registered one-hot (or one-cold) decode
//   out_valid   dec_out reflects a sel accepted on the previous edge
//   out_changed one-cycle pulse: dec_out differs from its previous value
//   oor_err     one-cycle pulse: the accepted sel was >= OUT_W
// -----------------------------------------------------------------------------
module decoder_onehot_reg #(
    parameter int SEL_W      = 3,
    parameter int OUT_W      = 8,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sel_valid,
    input  logic [SEL_W-1:0] sel,
    output logic [OUT_W-1:0] dec_out,
    output logic             out_valid,
    output logic             out_changed,
    output logic             oor_err
);

    // Value of dec_out when no line is selected.
    localparam logic [OUT_W-1:0] INACTIVE = ACTIVE_LOW ? {OUT_W{1'b1}} : {OUT_W{1'b0}};

    logic [OUT_W-1:0] dec_out_q,     dec_out_d;
    logic             out_valid_q,   out_valid_d;
    logic             out_changed_q, out_changed_d;
    logic             oor_err_q,     oor_err_d;
    logic [OUT_W-1:0] hot;           // active-high decode of sel

    always_comb begin
        // NOTE: every signal gets a default first, so no path through this
        // block leaves a value unassigned and no latch is inferred.
        hot         = '0;
        dec_out_d   = dec_out_q;     // hold while en=1 and sel_valid=0
        out_valid_d = 1'b0;
        oor_err_d   = 1'b0;

        if (!en) begin
            dec_out_d = INACTIVE;
        end else if (sel_valid) begin
            // sel is only examined here, so an X on sel while nothing is
            // accepted cannot reach any register.
            for (int i = 0; i < OUT_W; i++) begin
                if (sel == SEL_W'(i)) begin
                    hot[i] = 1'b1;
                end
            end
            dec_out_d   = ACTIVE_LOW ? ~hot : hot;
            out_valid_d = 1'b1;
            // An out-of-range code matches no line.
            oor_err_d   = ~|hot;
        end

        // This single comparison covers all three cases: a change on accept,
        // a drop to inactive when disabled (only if a line was active), and
        // never on hold, because dec_out_d equals dec_out_q then.
        out_changed_d = (dec_out_d != dec_out_q);
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_out_q     <= INACTIVE;
            out_valid_q   <= 1'b0;
            out_changed_q <= 1'b0;
            oor_err_q     <= 1'b0;
        end else begin
            dec_out_q     <= dec_out_d;
            out_valid_q   <= out_valid_d;
            out_changed_q <= out_changed_d;
            oor_err_q     <= oor_err_d;
        end
    end

    assign dec_out     = dec_out_q;
    assign out_valid   = out_valid_q;
    assign out_changed = out_changed_q;
    assign oor_err     = oor_err_q;

endmodule

// File: tb/tb_decoder_onehot_reg.sv
// -----------------------------------------------------------------------------
// tb_decoder_onehot_reg
//
// Directed-vector bench for decoder_onehot_reg. Three instances share the same
// stimulus: the default 3-to-8 decoder, an OUT_W=6 variant for out-of-range
// codes, and an ACTIVE_LOW=1 variant for the one-cold decode.
// -----------------------------------------------------------------------------
module tb_decoder_onehot_reg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       sel_valid;
    logic [2:0] sel;

    logic [7:0] dec_out;
    logic       out_valid, out_changed, oor_err;
    logic [5:0] dec6;
    logic       valid6, changed6, oor6;
    logic [7:0] decl;
    logic       validl, changedl, oorl;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decoder_onehot_reg u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_valid(sel_valid), .sel(sel),
        .dec_out(dec_out), .out_valid(out_valid), .out_changed(out_changed),
        .oor_err(oor_err)
    );

    decoder_onehot_reg #(.SEL_W(3), .OUT_W(6), .ACTIVE_LOW(1'b0)) u_dut6 (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_valid(sel_valid), .sel(sel),
        .dec_out(dec6), .out_valid(valid6), .out_changed(changed6),
        .oor_err(oor6)
    );

    decoder_onehot_reg #(.SEL_W(3), .OUT_W(8), .ACTIVE_LOW(1'b1)) u_dutl (
        .clk(clk), .rst_n(rst_n), .en(en), .sel_valid(sel_valid), .sel(sel),
        .dec_out(decl), .out_valid(validl), .out_changed(changedl),
        .oor_err(oorl)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Check all four outputs of the default instance.
    task automatic check_main(input string tag, input logic [7:0] d, input logic v,
                              input logic c, input logic o);
        check({tag, ".dec"},     {24'h0, dec_out}, {24'h0, d});
        check({tag, ".valid"},   {31'h0, out_valid}, {31'h0, v});
        check({tag, ".changed"}, {31'h0, out_changed}, {31'h0, c});
        check({tag, ".oor"},     {31'h0, oor_err}, {31'h0, o});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_hot;

        // Reset with sel undriven (X) and the decoder idle.
        rst_n     = 1'b0;
        en        = 1'b0;
        sel_valid = 1'b0;
        sel       = 'x;
        step();
        step();
        check_main("reset", 8'h00, 1'b0, 1'b0, 1'b0);
        check("reset.low_dec", {24'h0, decl}, 32'h0000_00FF);
        check("reset.dec6", {26'h0, dec6}, 32'h0);
        rst_n = 1'b1;

        // Idle after release; the X on sel must not leak through.
        for (int i = 0; i < 2; i++) begin
            step();
            check_main("idle", 8'h00, 1'b0, 1'b0, 1'b0);
        end

        // Basic decode sequence.
        en        = 1'b1;
        sel_valid = 1'b1;
        sel       = 3'd2;
        step();
        check_main("sel2", 8'h04, 1'b1, 1'b1, 1'b0);
        check("sel2.low_dec", {24'h0, decl}, 32'h0000_00FB);
        check("sel2.dec6", {26'h0, dec6}, 32'h0000_0004);

        sel = 3'd6;
        step();
        check_main("sel6", 8'h40, 1'b1, 1'b1, 1'b0);
        check("sel6.dec6", {26'h0, dec6}, 32'h0);
        check("sel6.oor6", {31'h0, oor6}, 32'h1);

        sel = 3'd5;
        step();
        check_main("sel5", 8'h20, 1'b1, 1'b1, 1'b0);
        check("sel5.oor6", {31'h0, oor6}, 32'h0);

        // Repeated code: the decode holds and out_changed stays low.
        for (int i = 0; i < 3; i++) begin
            step();
            check_main("repeat5", 8'h20, 1'b1, 1'b0, 1'b0);
        end

        // Sweep every code.
        for (int i = 0; i < 8; i++) begin
            sel     = 3'(i);
            exp_hot = 8'h01 << i;
            step();
            check_main("sweep", exp_hot, 1'b1, 1'b1, 1'b0);
            check("sweep.low_dec", {24'h0, decl}, {24'h0, ~exp_hot});
        end
        check("sweep7.dec6", {26'h0, dec6}, 32'h0);
        check("sweep7.oor6", {31'h0, oor6}, 32'h1);
        check("sweep7.valid6", {31'h0, valid6}, 32'h1);

        // Asynchronous reset between edges while dec_out=8'h80.
        #3;
        rst_n = 1'b0;
        #1;
        check_main("async_rst", 8'h00, 1'b0, 1'b0, 1'b0);
        check("async_rst.low_dec", {24'h0, decl}, 32'h0000_00FF);
        en        = 1'b0;
        sel_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check_main("post_rst", 8'h00, 1'b0, 1'b0, 1'b0);

        // Accept sel=3, then hold with sel_valid low.
        en        = 1'b1;
        sel_valid = 1'b1;
        sel       = 3'd3;
        step();
        check_main("acc3", 8'h08, 1'b1, 1'b1, 1'b0);
        sel_valid = 1'b0;
        sel       = 'x;
        for (int i = 0; i < 2; i++) begin
            step();
            check_main("hold3", 8'h08, 1'b0, 1'b0, 1'b0);
        end

        // Disable: the active line drops with a one-cycle change pulse.
        en = 1'b0;
        step();
        check_main("dis1", 8'h00, 1'b0, 1'b1, 1'b0);
        check("dis1.low_dec", {24'h0, decl}, 32'h0000_00FF);
        step();
        check_main("dis2", 8'h00, 1'b0, 1'b0, 1'b0);

        // Disabled with sel_valid high: nothing is accepted.
        sel_valid = 1'b1;
        sel       = 3'd4;
        step();
        check_main("dis_sv", 8'h00, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
